// File: rtl/mirfak_hazard_ctrl.sv
// rtl/mirfak_hazard_ctrl.sv - Mirfak pipeline hazard, forwarding and flush sequencing controller
module mirfak_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned WAIT_TIMEOUT = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  id_raddr_a_i,
    input  logic [4:0]  id_raddr_b_i,
    input  logic        id_use_a_i,
    input  logic        id_use_b_i,
    input  logic [4:0]  ex_waddr_i,
    input  logic        ex_wen_i,
    input  logic        ex_is_load_i,
    input  logic        ex_stall_i,
    input  logic [4:0]  wb_waddr_i,
    input  logic        wb_wen_i,
    input  logic        take_branch_i,
    input  logic        trap_i,
    output logic [1:0]  id_fwd_a_sel_o,
    output logic [1:0]  id_fwd_b_sel_o,
    output logic        ifid_enable_o,
    output logic        ifid_clear_o,
    output logic        idex_enable_o,
    output logic        idex_clear_o,
    output logic        exwb_enable_o,
    output logic        exwb_clear_o,
    output logic        timeout_o,
    output logic [31:0] stall_cycles_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [3:0]  FLUSH_LOAD = 4'(FLUSH_CYCLES);
    localparam logic [15:0] WAIT_MAX   = 16'(WAIT_TIMEOUT);
    localparam logic [15:0] WAIT_LAST  = 16'(WAIT_TIMEOUT - 1);

    state_t      state;
    logic [3:0]  flush_cnt;
    logic [15:0] wait_cnt;
    logic        load_use;

    // Loads are only forwardable once they reach WB, so an EX load hides nothing.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] raddr,
        input logic [4:0] ex_waddr,
        input logic       ex_wen,
        input logic       ex_is_load,
        input logic [4:0] wb_waddr,
        input logic       wb_wen
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (raddr == 5'd0) begin
            sel = 2'b00;
        end else if (ex_wen && !ex_is_load && (ex_waddr == raddr)) begin
            sel = 2'b01;
        end else if (wb_wen && (wb_waddr == raddr)) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        load_use = ex_is_load_i && ex_wen_i && (ex_waddr_i != 5'd0) &&
                   ((id_use_a_i && (ex_waddr_i == id_raddr_a_i)) ||
                    (id_use_b_i && (ex_waddr_i == id_raddr_b_i)));
    end

    always_comb begin
        id_fwd_a_sel_o = 2'b00;
        id_fwd_b_sel_o = 2'b00;
        ifid_enable_o  = 1'b1;
        ifid_clear_o   = 1'b0;
        idex_enable_o  = 1'b1;
        idex_clear_o   = 1'b0;
        exwb_enable_o  = 1'b1;
        exwb_clear_o   = 1'b0;
        if (!rst_ni) begin
            ifid_enable_o = 1'b0;
            ifid_clear_o  = 1'b1;
            idex_enable_o = 1'b0;
            idex_clear_o  = 1'b1;
            exwb_enable_o = 1'b0;
            exwb_clear_o  = 1'b1;
        end else begin
            id_fwd_a_sel_o = fwd_sel(id_raddr_a_i, ex_waddr_i, ex_wen_i, ex_is_load_i,
                                     wb_waddr_i, wb_wen_i);
            id_fwd_b_sel_o = fwd_sel(id_raddr_b_i, ex_waddr_i, ex_wen_i, ex_is_load_i,
                                     wb_waddr_i, wb_wen_i);
            if (trap_i) begin
                ifid_enable_o = 1'b0;
                ifid_clear_o  = 1'b1;
                idex_enable_o = 1'b0;
                idex_clear_o  = 1'b1;
                exwb_enable_o = 1'b0;
                exwb_clear_o  = 1'b1;
            end else if (state == ST_FLUSH) begin
                ifid_enable_o = 1'b0;
                ifid_clear_o  = 1'b1;
            end else if (ex_stall_i) begin
                ifid_enable_o = 1'b0;
                idex_enable_o = 1'b0;
                exwb_enable_o = 1'b0;
                exwb_clear_o  = 1'b1;
            end else if (load_use) begin
                ifid_enable_o = 1'b0;
                idex_enable_o = 1'b0;
                idex_clear_o  = 1'b1;
            end else if (take_branch_i) begin
                ifid_enable_o = 1'b0;
                ifid_clear_o  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state          <= ST_RUN;
            flush_cnt      <= 4'd0;
            wait_cnt       <= 16'd0;
            timeout_o      <= 1'b0;
            stall_cycles_o <= 32'd0;
        end else begin
            stall_cycles_o <= stall_cycles_o + {31'd0, ~idex_enable_o};
            timeout_o      <= 1'b0;
            if (trap_i) begin
                state     <= ST_FLUSH;
                flush_cnt <= FLUSH_LOAD;
                wait_cnt  <= 16'd0;
            end else if (state == ST_FLUSH) begin
                if (flush_cnt <= 4'd1) begin
                    state     <= ST_RUN;
                    flush_cnt <= 4'd0;
                end else begin
                    flush_cnt <= flush_cnt - 4'd1;
                end
            end else if (ex_stall_i) begin
                state <= ST_WAIT;
                if (wait_cnt != WAIT_MAX) begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
                // Fires only on the step into saturation, so one pulse per WAIT visit.
                if (wait_cnt == WAIT_LAST) begin
                    timeout_o <= 1'b1;
                end
            end else begin
                state    <= ST_RUN;
                wait_cnt <= 16'd0;
            end
        end
    end

endmodule

// File: doc/mirfak_hazard_ctrl.md
# mirfak_hazard_ctrl

Pipeline sequencing controller for the Mirfak core. It generates the forwarding selects consumed by the ID stage and the enable/clear strobes for the IF/ID, ID/EX and EX/WB pipeline registers. It resolves load-use hazards, multi-cycle EX stalls (LSU/MDU wait), taken-branch kills and trap flushes through a small state machine. It also provides a stall watchdog and a stall-cycle performance counter.

## Interface
- FLUSH_CYCLES, 1: cycles IF/ID stays cleared after a trap; legal range 1..15.
- WAIT_TIMEOUT, 1024: consecutive EX-stall cycles before `timeout_o` fires; legal range 2..65535.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, synchronous and active-low.
- id_raddr_a_i / id_raddr_b_i  in  5  source registers of the instruction in ID.
- id_use_a_i / id_use_b_i  in  1  the ID instruction actually reads rs1 / rs2.
- ex_waddr_i  in  5  destination register of the instruction in EX.
- ex_wen_i  in  1  the EX instruction writes the register file.
- ex_is_load_i  in  1  the EX instruction is a load, so its result is not forwardable from EX.
- ex_stall_i  in  1  EX cannot complete this cycle (LSU or MDU pending).
- wb_waddr_i  in  5  destination register of the instruction in WB.
- wb_wen_i  in  1  the WB instruction writes the register file.
- take_branch_i  in  1  taken branch/jump in ID; already gated by ID/EX enable.
- trap_i  in  1  exception/trap committed in WB.
- id_fwd_a_sel_o / id_fwd_b_sel_o  out  2  source select: 00 regfile, 01 EX, 10 WB.
- ifid_enable_o, ifid_clear_o, idex_enable_o, idex_clear_o, exwb_enable_o, exwb_clear_o  out  1 each  pipeline register strobes.
- timeout_o  out  1  registered one-cycle pulse on stall watchdog expiry.
- stall_cycles_o  out  32  registered count of cycles with `idex_enable_o`=0.

## Operation
- Forwarding (combinational, per operand X):
  - Select 00 if raddr_X=0.
  - Otherwise select 01 if ex_wen_i, ex_waddr_i=raddr_X and !ex_is_load_i.
  - Otherwise select 10 if wb_wen_i and wb_waddr_i=raddr_X.
  - Otherwise select 00.
  - EX has priority over WB.
- Load-use hazard: ex_is_load_i & ex_wen_i & ex_waddr_i≠0, and ex_waddr_i equals a used source (id_use_X_i).
- States: RUN, WAIT, FLUSH. Per-cycle priority: trap_i > ex_stall_i > load-use > take_branch_i.
- trap_i (any state):
  - Strobes: ifid_clear=idex_clear=exwb_clear=1.
  - Next state FLUSH; flush counter loads FLUSH_CYCLES; the wait counter is cleared.
- ex_stall_i (no trap):
  - Strobes: ifid_enable=idex_enable=0, exwb_clear=1 (a bubble enters WB).
  - Next state WAIT. The wait counter increments each stalled cycle and saturates at WAIT_TIMEOUT.
- Load-use (no trap/stall):
  - Strobes: ifid_enable=0, idex_clear=1 (a bubble enters EX), exwb_enable=1.
  - The following cycle the load sits in WB and forwarding selects 10.
- take_branch_i (no higher event): ifid_clear=1, idex_enable=exwb_enable=1.
- Default (RUN): all enables 1, all clears 0.
- WAIT: exit to RUN on the first cycle with ex_stall_i=0; the wait counter clears.
- FLUSH:
  - ifid_clear=1; idex_enable=exwb_enable=1.
  - The counter decrements each cycle; return to RUN on the edge where the counter equals 1.
  - ex_stall_i, load-use and take_branch_i are ignored in FLUSH. A new trap_i reloads the counter.
- Whenever a clear is 1, the same register's enable is a don't-care and is driven 0.
- timeout_o pulses exactly once when the wait counter reaches WAIT_TIMEOUT. It does not repeat until WAIT is left.
- stall_cycles_o increments on every cycle with idex_enable_o=0 and wraps from 2^32−1 to 0.

## Timing
- Forwarding selects and pipeline strobes are combinational from the current state and inputs: zero-cycle latency. Neither timeout_o nor stall_cycles_o depends combinationally on the strobes' consumers.
- timeout_o and stall_cycles_o are registered and reflect the previous cycle.
- Reset (rst_ni=0 at an edge):
  - State becomes RUN; all counters become 0; timeout_o becomes 0.
  - While rst_ni=0, the strobes are forced to clears=1, enables=0 and fwd selects=00.
- Reset mid-WAIT or mid-FLUSH abandons the operation; the block resumes in RUN with no pending timeout.
- Simultaneous trap_i and ex_stall_i: the flush wins, and the wait counter does not increment.
- A load-use stall lasts exactly 1 cycle unless ex_stall_i rises.

## Test plan
- **Forwarding:** EX writes x5 (non-load) and WB writes x5; ID reads x5 on rs1 → fwd_a=01. Drop ex_wen_i → fwd_a=10. Set rs1=x0 → fwd_a=00.
- **Load-use:** EX load x7, ID uses rs2=x7 → one cycle with ifid_enable=0, idex_clear=1. Next cycle, load in WB → fwd_b=10 and all enables 1. With id_use_b_i=0 there is no stall.
- **EX stall:** ex_stall_i high for 3 cycles → idex_enable=0 and exwb_clear=1 for 3 cycles, stall_cycles_o +3, back to RUN. With WAIT_TIMEOUT=4 and a 10-cycle stall → timeout_o pulses exactly once, one cycle after the 4th stalled cycle.
- **Trap flush:** FLUSH_CYCLES=2, trap_i during WAIT → all three clears in that cycle, then ifid_clear for 2 cycles, then RUN. take_branch_i during FLUSH is ignored.
- **Branch kill:** take_branch_i with no hazard → ifid_clear=1, idex_enable=1. take_branch_i together with load-use → the stall wins and ifid_clear=0.
- **Reset:** rst_ni=0 mid-FLUSH → the next cycle is RUN, stall_cycles_o=0, timeout_o=0; clears=1 while reset is held.
